mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 149 ++++++++++++++
 tb/tb_mem_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with EX/MEM and MEM/WB registers.
// Handles a handshaked data-memory port (req/ack), upstream stall generation,
// and a bounded wait. On timeout the access is abandoned, a sticky error flag
// is raised, and a zero load value is passed onward.
module mem_stage #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  EXMWB,
   input  logic [2:0]  EXMM,
   input  logic [31:0] EXALUOut,
   input  logic [31:0] EXMWriteData,
   input  logic [4:0]  regtopass,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] MEMALUOut,
   output logic [4:0]  EXMEMRegRd,
   output logic [1:0]  EXMEM_RegWrite,
   output logic [31:0] datatowrite,
   output logic [4:0]  MEMWBRegRd,
   output logic [1:0]  MEMWB_RegWrite,
   output logic        stall,
   output logic        mem_err
);

   localparam logic [4:0] TMO = 5'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ERR
   } state_t;

   state_t      state, next_state;
   logic [4:0]  wait_cnt;

   // EX/MEM register contents
   logic [1:0]  exm_wb;
   logic [2:0]  exm_m;
   logic [31:0] exm_alu;
   logic [31:0] exm_wdata;
   logic [4:0]  exm_rd;

   // MEM/WB register contents
   logic [1:0]  mwb_wb;
   logic [31:0] mwb_alu;
   logic [31:0] mwb_load;
   logic [4:0]  mwb_rd;

   logic        memop;
   logic [31:0] load_val;

   // Branch is carried through EX/MEM but has no consumer in this stage
   logic        unused_branch;
   assign unused_branch = exm_m[2];

   // Memory port, stall and load selection
   always_comb begin
      memop     = exm_m[0] | exm_m[1];
      mem_req   = memop & (state != S_ERR);
      mem_we    = exm_m[1] & mem_req;
      mem_addr  = exm_alu;
      mem_wdata = exm_wdata;
      stall     = mem_req & ~mem_ack;
      // Only data returned with an ack is a real load; abandoned accesses give 0
      load_val  = (mem_req & mem_ack) ? mem_rdata : '0;
   end

   // Forwarding and writeback outputs
   always_comb begin
      MEMALUOut      = exm_alu;
      EXMEMRegRd     = exm_rd;
      EXMEM_RegWrite = exm_wb;
      MEMWBRegRd     = mwb_rd;
      MEMWB_RegWrite = mwb_wb;
      datatowrite    = mwb_wb[1] ? mwb_load : mwb_alu;
   end

   // EX/MEM register: capture when not stalled, hold otherwise
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         exm_wb    <= '0;
         exm_m     <= '0;
         exm_alu   <= '0;
         exm_wdata <= '0;
         exm_rd    <= '0;
      end else if (!stall) begin
         exm_wb    <= EXMWB;
         exm_m     <= EXMM;
         exm_alu   <= EXALUOut;
         exm_wdata <= EXMWriteData;
         exm_rd    <= regtopass;
      end
   end

   // MEM/WB register: capture when not stalled, insert a bubble when stalled
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mwb_wb   <= '0;
         mwb_alu  <= '0;
         mwb_load <= '0;
         mwb_rd   <= '0;
      end else if (stall) begin
         mwb_wb   <= '0;
      end else begin
         mwb_wb   <= exm_wb;
         mwb_alu  <= exm_alu;
         mwb_load <= load_val;
         mwb_rd   <= exm_rd;
      end
   end

   // Access FSM next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (stall) next_state = S_WAIT;
         S_WAIT: begin
            if (mem_ack)              next_state = S_IDLE;
            else if (wait_cnt == TMO) next_state = S_ERR;
         end
         S_ERR:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // FSM state, saturating wait counter and sticky error flag
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_WAIT) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 5'd1;
         end else begin
            wait_cnt <= '0;
         end
         if (next_state == S_ERR) mem_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;

   logic        clock;
   logic        reset_n;
   logic [1:0]  EXMWB;
   logic [2:0]  EXMM;
   logic [31:0] EXALUOut;
   logic [31:0] EXMWriteData;
   logic [4:0]  regtopass;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] MEMALUOut;
   logic [4:0]  EXMEMRegRd;
   logic [1:0]  EXMEM_RegWrite;
   logic [31:0] datatowrite;
   logic [4:0]  MEMWBRegRd;
   logic [1:0]  MEMWB_RegWrite;
   logic        stall;
   logic        mem_err;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned stall_cycles;

   mem_stage #(.TIMEOUT(15)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .EXMWB          (EXMWB),
      .EXMM           (EXMM),
      .EXALUOut       (EXALUOut),
      .EXMWriteData   (EXMWriteData),
      .regtopass      (regtopass),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack),
      .MEMALUOut      (MEMALUOut),
      .EXMEMRegRd     (EXMEMRegRd),
      .EXMEM_RegWrite (EXMEM_RegWrite),
      .datatowrite    (datatowrite),
      .MEMWBRegRd     (MEMWBRegRd),
      .MEMWB_RegWrite (MEMWB_RegWrite),
      .stall          (stall),
      .mem_err        (mem_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive_ex(input logic [1:0] wb, input logic [2:0] m,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rd);
      EXMWB        = wb;
      EXMM         = m;
      EXALUOut     = alu;
      EXMWriteData = wd;
      regtopass    = rd;
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      drive_ex(2'b00, 3'b000, '0, '0, '0);

      // Reset state, before any clock edge
      #2;
      check("rst_req",   32'(mem_req), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_dtw",   datatowrite, 32'd0);
      check("rst_err",   32'(mem_err), 32'd0);
      step;
      step;
      reset_n = 1'b1;

      // ALU op passes through in two edges, no stall
      drive_ex(2'b01, 3'b000, 32'h1234, 32'h0, 5'd5);
      step;
      drive_ex(2'b00, 3'b000, '0, '0, '0);
      @(negedge clock);
      check("alu_exm_alu",   MEMALUOut, 32'h1234);
      check("alu_exm_rd",    32'(EXMEMRegRd), 32'd5);
      check("alu_exm_wb",    32'(EXMEM_RegWrite), 32'd1);
      check("alu_stall",     32'(stall), 32'd0);
      step;
      check("alu_dtw",       datatowrite, 32'h1234);
      check("alu_mwb_rd",    32'(MEMWBRegRd), 32'd5);
      check("alu_mwb_wb",    32'(MEMWB_RegWrite), 32'd1);

      // Zero-wait load
      drive_ex(2'b11, 3'b001, 32'h40, 32'h0, 5'd7);
      step;
      drive_ex(2'b00, 3'b000, '0, '0, '0);
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      @(negedge clock);
      check("zw_req",   32'(mem_req), 32'd1);
      check("zw_we",    32'(mem_we), 32'd0);
      check("zw_addr",  mem_addr, 32'h40);
      check("zw_stall", 32'(stall), 32'd0);
      step;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD0BAD;
      check("zw_dtw",    datatowrite, 32'hDEADBEEF);
      check("zw_mwb_wb", 32'(MEMWB_RegWrite), 32'd3);
      check("zw_mwb_rd", 32'(MEMWBRegRd), 32'd7);

      // Store acked after three stalled cycles, preceded by an ALU op
      drive_ex(2'b01, 3'b000, 32'h55, 32'h0, 5'd3);
      step;
      drive_ex(2'b00, 3'b010, 32'h80, 32'hCAFEF00D, 5'd0);
      step;
      drive_ex(2'b01, 3'b000, 32'h999, 32'h0, 5'd9);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check($sformatf("st_stall%0d", i), 32'(stall), 32'd1);
         check($sformatf("st_we%0d", i),    32'(mem_we), 32'd1);
         check($sformatf("st_addr%0d", i),  mem_addr, 32'h80);
         check($sformatf("st_wd%0d", i),    mem_wdata, 32'hCAFEF00D);
         step;
         check($sformatf("st_bubble%0d", i), 32'(MEMWB_RegWrite), 32'd0);
      end
      mem_ack = 1'b1;
      @(negedge clock);
      check("st_ack_stall", 32'(stall), 32'd0);
      check("st_ack_we",    32'(mem_we), 32'd1);
      step;
      mem_ack = 1'b0;
      check("st_next_alu", MEMALUOut, 32'h999);
      check("st_next_rd",  32'(EXMEMRegRd), 32'd9);
      step;
      check("st_next_dtw", datatowrite, 32'h999);
      check("st_next_wb",  32'(MEMWB_RegWrite), 32'd1);
      check("st_noerr",    32'(mem_err), 32'd0);

      // Load that is never acked: timeout then ERR
      drive_ex(2'b11, 3'b001, 32'h100, 32'h0, 5'd4);
      step;
      drive_ex(2'b00, 3'b000, '0, '0, '0);
      mem_rdata    = 32'h12345678;
      stall_cycles = 0;
      while (stall_cycles < 40) begin
         @(negedge clock);
         if (!stall) break;
         stall_cycles++;
         step;
      end
      // First stalled cycle is the request itself; the rest are wait cycles
      check("to_wait_cycles", stall_cycles - 1, 32'd16);
      check("to_err_req",     32'(mem_req), 32'd0);
      check("to_err_stall",   32'(stall), 32'd0);
      drive_ex(2'b01, 3'b000, 32'h77, 32'h0, 5'd2);
      step;
      drive_ex(2'b00, 3'b000, '0, '0, '0);
      check("to_err_flag",  32'(mem_err), 32'd1);
      check("to_load_zero", datatowrite, 32'd0);
      check("to_mwb_wb",    32'(MEMWB_RegWrite), 32'd3);
      check("to_mwb_rd",    32'(MEMWBRegRd), 32'd4);
      check("to_resume",    MEMALUOut, 32'h77);
      step;
      check("to_resume_dtw", datatowrite, 32'h77);
      check("to_err_sticky", 32'(mem_err), 32'd1);

      // Reset asserted while waiting on a store
      drive_ex(2'b01, 3'b010, 32'h200, 32'hA5A5A5A5, 5'd6);
      step;
      drive_ex(2'b00, 3'b000, '0, '0, '0);
      step;
      step;
      @(negedge clock);
      check("rw_pre_stall", 32'(stall), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rw_req",    32'(mem_req), 32'd0);
      check("rw_stall",  32'(stall), 32'd0);
      check("rw_we",     32'(mem_we), 32'd0);
      check("rw_addr",   mem_addr, 32'd0);
      check("rw_exm_wb", 32'(EXMEM_RegWrite), 32'd0);
      check("rw_err",    32'(mem_err), 32'd0);
      step;
      reset_n = 1'b1;
      @(negedge clock);
      check("rw_post_req", 32'(mem_req), 32'd0);
      check("rw_post_err", 32'(mem_err), 32'd0);

      // After reset a fresh load with one wait cycle completes normally
      drive_ex(2'b11, 3'b001, 32'h300, 32'h0, 5'd8);
      step;
      drive_ex(2'b00, 3'b000, '0, '0, '0);
      @(negedge clock);
      check("rw_new_stall", 32'(stall), 32'd1);
      step;
      mem_ack   = 1'b1;
      mem_rdata = 32'h0000BEEF;
      @(negedge clock);
      check("rw_new_nostall", 32'(stall), 32'd0);
      step;
      mem_ack = 1'b0;
      check("rw_new_dtw", datatowrite, 32'h0000BEEF);
      check("rw_new_wb",  32'(MEMWB_RegWrite), 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
